bless_mc_port_alloc: RTL

//  Per-router output-port allocator for the bufferless multicast (BLESS-MC) router.
//  - Ranks the up to 4 arriving flits, oldest first.
//  - Grants each flit its free productive ports; a multicast flit may replicate to several.
//  - Deflects any flit left without a grant to a free network port.
//  - Outputs a registered per-input allocPV plus the aligned dstList. Both feed the
//    per-output-port dstMgmt instances.

---
 rtl/bless_mc_port_alloc_pkg.sv | 28 ++
 rtl/bless_mc_rank.sv | 42 ++++
 rtl/bless_mc_port_alloc.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bless_mc_port_alloc_pkg.sv
// Shared constants and helpers for the BLESS-MC output-port allocator.
package bless_mc_port_alloc_pkg;

  localparam int NUM_PORT       = 5;
  localparam int DST_LIST_WIDTH = 16;
  localparam int AGE_W_DEF      = 4;

  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_S = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  localparam logic [NUM_PORT-1:0] N_MASK = 5'b00001;
  localparam logic [NUM_PORT-1:0] E_MASK = 5'b00010;
  localparam logic [NUM_PORT-1:0] S_MASK = 5'b00100;
  localparam logic [NUM_PORT-1:0] W_MASK = 5'b01000;
  localparam logic [NUM_PORT-1:0] L_MASK = 5'b10000;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    popcnt4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [2:0] popcnt5(input logic [4:0] v);
    popcnt5 = popcnt4(v[3:0]) + 3'(v[4]);
  endfunction

endpackage

// File: rtl/bless_mc_rank.sv
// Combinational flit ranker: oldest first, ties broken by distance from rr_ptr.
// Invalid flits sort after all valid ones so order[] is always a permutation.
module bless_mc_rank
  #(parameter int AGE_W = 4)
  (
    input  logic [3:0]         valid,
    input  logic [4*AGE_W-1:0] age,
    input  logic [1:0]         rr_ptr,
    output logic [3:0][1:0]    order
  );

  logic [3:0][AGE_W-1:0] age_a;
  logic [1:0]            pos;

  assign age_a = age;

  function automatic logic beats(input logic va, input logic vb,
                                 input logic [AGE_W-1:0] aa, input logic [AGE_W-1:0] ab,
                                 input logic [1:0] ra, input logic [1:0] rb);
    if (va != vb)
      beats = va;
    else if (va && (aa != ab))
      beats = (aa > ab);
    else
      beats = (ra < rb);
  endfunction

  always_comb begin
    order = '0;
    pos   = '0;
    for (int i = 0; i < 4; i++) begin
      pos = '0;
      for (int j = 0; j < 4; j++) begin
        if (j != i && beats(valid[j], valid[i], age_a[j], age_a[i],
                            2'(j) - rr_ptr, 2'(i) - rr_ptr))
          pos = pos + 2'd1;
      end
      order[pos] = 2'(i);
    end
  end

endmodule

// File: rtl/bless_mc_port_alloc.sv
// BLESS-MC per-router output-port allocator: productive/replica pass, then deflection pass.
// Define MC_ALLOC_STATS_EN to build the saturating deflection/replica counters.
module bless_mc_port_alloc
  import bless_mc_port_alloc_pkg::*;
  #(
    parameter int AGE_W  = AGE_W_DEF,
    parameter int NUM_IN = 4,
    parameter int CNT_W  = 16
  )
  (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_IN-1:0]                in_valid,
    input  logic [NUM_IN*AGE_W-1:0]          in_age,
    input  logic [NUM_IN*DST_LIST_WIDTH-1:0] in_dst,
    input  logic [NUM_IN*NUM_PORT-1:0]       in_prod,
    input  logic                             eject_rdy,
    output logic [NUM_IN-1:0]                out_valid,
    output logic [NUM_IN*NUM_PORT-1:0]       out_allocPV,
    output logic [NUM_IN*DST_LIST_WIDTH-1:0] out_dst,
    output logic [1:0]                       rr_ptr,
    output logic [CNT_W-1:0]                 defl_cnt,
    output logic [CNT_W-1:0]                 repl_cnt
  );

  logic [3:0][1:0]          order;
  logic [3:0][NUM_PORT-1:0] prod_a;
  logic [3:0][NUM_PORT-1:0] grant;
  logic [3:0]               free_net;
  logic                     l_free;
  logic [1:0]               idx;
  logic [NUM_PORT-1:0]      avail;
  logic                     found;
  logic [2:0]               lower;

  assign prod_a = in_prod;

  bless_mc_rank #(.AGE_W(AGE_W)) u_rank (
    .valid  (in_valid),
    .age    (in_age),
    .rr_ptr (rr_ptr),
    .order  (order)
  );

  always_comb begin
    grant    = '0;
    free_net = 4'hF;
    l_free   = eject_rdy;
    idx      = '0;
    avail    = '0;
    found    = 1'b0;
    lower    = '0;

    for (int k = 0; k < 4; k++) begin
      idx   = order[k];
      avail = prod_a[idx] & {l_free, free_net};
      if (in_valid[idx] && (avail != '0)) begin
        found = 1'b0;
        for (int p = 0; p < NUM_PORT; p++) begin
          if (avail[p] && !found) begin
            found         = 1'b1;
            grant[idx][p] = 1'b1;
          end
        end
        l_free   = l_free & ~grant[idx][PORT_L];
        free_net = free_net & ~grant[idx][3:0];
        lower    = '0;
        for (int m = 0; m < 4; m++) begin
          if (m > k)
            lower = lower + {2'b00, in_valid[order[m]]};
        end
        // A replica may only consume a network port that no lower-ranked flit will need.
        for (int p = 0; p < 4; p++) begin
          if (prod_a[idx][p] && free_net[p] && ((popcnt4(free_net) - 3'd1) >= lower)) begin
            grant[idx][p] = 1'b1;
            free_net[p]   = 1'b0;
          end
        end
      end
    end

    for (int k = 0; k < 4; k++) begin
      idx   = order[k];
      found = 1'b0;
      if (in_valid[idx] && (grant[idx] == '0)) begin
        for (int p = 0; p < 4; p++) begin
          if (free_net[p] && !found) begin
            found         = 1'b1;
            grant[idx][p] = 1'b1;
            free_net[p]   = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid   <= '0;
      out_allocPV <= '0;
      out_dst     <= '0;
      rr_ptr      <= '0;
    end else begin
      out_valid   <= in_valid;
      out_allocPV <= grant;
      out_dst     <= in_dst;
      if (|in_valid)
        rr_ptr <= rr_ptr + 2'd1;
    end
  end

`ifdef MC_ALLOC_STATS_EN
  logic [2:0]     defl_num;
  logic [2:0]     repl_num;
  logic [CNT_W:0] defl_sum;
  logic [CNT_W:0] repl_sum;

  // A deflected flit never holds one of its productive ports: pass 1 would have taken it.
  always_comb begin
    defl_num = '0;
    repl_num = '0;
    for (int i = 0; i < 4; i++) begin
      if (in_valid[i]) begin
        if ((grant[i] & prod_a[i]) == '0)
          defl_num = defl_num + 3'd1;
        repl_num = repl_num + popcnt5(grant[i]) - 3'd1;
      end
    end
  end

  assign defl_sum = {1'b0, defl_cnt} + (CNT_W+1)'(defl_num);
  assign repl_sum = {1'b0, repl_cnt} + (CNT_W+1)'(repl_num);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      defl_cnt <= '0;
      repl_cnt <= '0;
    end else begin
      defl_cnt <= defl_sum[CNT_W] ? '1 : defl_sum[CNT_W-1:0];
      repl_cnt <= repl_sum[CNT_W] ? '1 : repl_sum[CNT_W-1:0];
    end
  end
`else
  assign defl_cnt = '0;
  assign repl_cnt = '0;
`endif

endmodule
